mul16_seq: RTL and testbench
============================

# mul16_seq

Sequential 16x16 unsigned multiplier controller built around the existing `and16` bitwise-AND datapath. It uses one `and16` instance to form each partial product (multiplicand AND replicated multiplier bit). An FSM accumulates the partial products over successive cycles with a start/busy/done handshake. It sits beside the 16-bit ALU and serves the multiply instruction, which has no single-cycle datapath.

## Interface
Parameters:
- none; operand width is fixed at 16 (`WIDTH` in `mul16_pkg`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `in1`  in  16  multiplicand; captured on the accepting edge.
- `in2`  in  16  multiplier; captured on the accepting edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; high exactly while the state is DONE.
- `out`  out  32  unsigned product `in1*in2`; holds its value until the next result or reset.

## Operation
- Internal registers:
  - `a` (16 bits): multiplicand.
  - `b` (16 bits): multiplier, shifted right one bit per step.
  - `acc` (32 bits): running sum.
  - `cnt` (4 bits): step index.
  - `state`.
- States:
  - IDLE:
    - On `start=1`: load `a<=in1`, `b<=in2`, `acc<=0`, `cnt<=0`, then go to RUN.
    - On `start=0`: stay in IDLE.
  - RUN, every edge:
    - `p = and16(a, {16{b[0]}})`.
    - `acc <= acc + (p << cnt)`, zero-extended to 32 bits with no overflow possible.
    - `b <= b >> 1`, `cnt <= cnt+1`.
    - When `cnt==15`: `out <= acc + (p<<15)` and go to DONE.
  - DONE: `done=1` for one cycle, then unconditionally go to IDLE.
- `start` is ignored while `busy=1`. Operands are not resampled, and there is no queueing.
- Reset values: state IDLE, `busy=0`, `done=0`, `out=0`, all internal registers 0.
- Reset mid-RUN or mid-DONE aborts the operation immediately:
  - no `done` pulse is issued;
  - `out` is forced to 0.
- `start` held high continuously is accepted again on the first edge in IDLE after DONE.

## Timing
- Accepting edge E0 is the edge with IDLE and `start=1`.
- RUN edges are E1..E16.
- At E16 the state becomes DONE, `out` is valid, and `done=1`. At E17 the state returns to IDLE.
- Latency: `done` is visible 16 cycles after the accepting edge. Throughput is one product per 18 cycles with `start` held high.
- `busy` rises after E0 and falls after E17.
- `out` changes only at the edge that enters DONE, or on reset.

## Configuration
- `MUL16_EARLY_EXIT_EN` defined:
  - In RUN, go to DONE when the shifted `b` becomes 0 or when `cnt==15`, whichever comes first. `out` is loaded with the final `acc` at that edge.
  - If `in2==0` at E0, go directly from IDLE to DONE with `out<=0`, so `done` is visible after E0.
  - Otherwise `done` is visible after edge E(m+1), where `m` is the index of the most significant set bit of `in2`.
- `MUL16_EARLY_EXIT_EN` undefined: fixed 16-step latency as above, independent of operand values.

## Structure
- `mul16_pkg` contains:
  - `WIDTH=16`, `PROD_W=32`, `CNT_W=4`;
  - state typedef enum {IDLE, RUN, DONE} `mul16_state_t`.
- Sub-module: one `and16` instance for the partial product. The adder and shifter are inline in `mul16_seq`.

## Test plan
- Reset after 5 RUN cycles (3*5 in flight):
  - `busy`, `done` and `out` drop to 0 asynchronously.
  - After release, a `start` with 2*2 completes with `out=4`.
- `in1=3`, `in2=5`, start pulse at E0:
  - `done=1` only in the cycle after E16, with `out=0x0000000F`.
  - `busy` high from E0 to E17.
- `in1=0xFFFF`, `in2=0xFFFF`: `out=0xFFFE0001`. Also `in1=0x8000`, `in2=0x0002`: `out=0x00010000`.
- `start` with 7*9, then a second `start` with 100*100 at E5 while busy: `out=63`, and the second request is not executed.
- `start` held high with constant 0x1234*0x0010: products at E16 and E34, both `out=0x00012340`, with a single-cycle `done` each time.
- With `MUL16_EARLY_EXIT_EN`:
  - 0x1234*1 gives `done` after E1 with `out=0x00001234`.
  - 0xABCD*0 gives `done` after E0 with `out=0`.
  - 0xFFFF*0x8000 still takes 16 steps, with `out=0x7FFF8000`.

Source files
------------

// File: rtl/mul16_pkg.sv
// Shared widths and FSM state encoding for the sequential 16x16 multiplier.
package mul16_pkg;
    localparam int WIDTH  = 16;
    localparam int PROD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul16_state_t;
endpackage

// File: rtl/mul16_seq_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier.
interface mul16_seq_if;
    import mul16_pkg::*;

    logic              start;
    logic [WIDTH-1:0]  in1;
    logic [WIDTH-1:0]  in2;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] out;

    modport master (output start, in1, in2, input busy, done, out);
    modport slave  (input start, in1, in2, output busy, done, out);
endinterface

// File: rtl/and16.sv
// 16-bit bitwise AND; forms one partial product per multiplier step.
module and16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

// File: rtl/mul16_seq.sv
// Shift-and-add 16x16 unsigned multiplier, one partial product per cycle.
// Optional early termination is enabled by defining MUL16_EARLY_EXIT_EN.
module mul16_seq
    import mul16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mul16_seq_if.slave  bus
);
    mul16_state_t      r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [PROD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [PROD_W-1:0] r_out;
    logic              r_busy;
    logic              r_done;

    logic [WIDTH-1:0]  w_p;
    logic [PROD_W-1:0] w_sum;
    logic [WIDTH-1:0]  w_b_next;
    logic              w_last;

    and16 u_and16 (
        .i_a (r_a),
        .i_b ({WIDTH{r_b[0]}}),
        .o_y (w_p)
    );

    always_comb begin
        w_sum    = r_acc + ({{(PROD_W-WIDTH){1'b0}}, w_p} << r_cnt);
        w_b_next = r_b >> 1;
`ifdef MUL16_EARLY_EXIT_EN
        // No set multiplier bits remain, so later steps would add nothing.
        w_last   = (r_cnt == LAST_CNT) || (w_b_next == '0);
`else
        w_last   = (r_cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a    <= bus.in1;
                        r_b    <= bus.in2;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef MUL16_EARLY_EXIT_EN
                        if (bus.in2 == '0) begin
                            r_out   <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
`else
                        r_state <= RUN;
`endif
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_b   <= w_b_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_sum;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: vector table plus handshake corner cases.
module tb_mul16_seq;
    logic clk;
    logic rst;

    mul16_seq_if u_if ();

    mul16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] sb [$];
    int          checks;
    int          errors;

    function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL16_EARLY_EXIT_EN
        int m;
        if (b == 16'h0) return 0;
        m = 0;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        return m + 1;
`else
        return (b == 16'h0) ? 16 : 16;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Counts edges from E0 (already driven) until done is seen at a negedge.
    task automatic wait_done(input int lat, input bit drop, input string nm);
        bit seen;
        logic [31:0] e;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            if (drop && n == 0) begin
                #1 u_if.start = 1'b0;
                check({nm, " busy after E0"}, {31'b0, u_if.busy}, 32'd1);
            end
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                check({nm, " latency"}, n, lat);
                if (sb.size() == 0) begin
                    check({nm, " unexpected done"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({nm, " out"}, u_if.out, e);
                end
                break;
            end
        end
        if (!seen) check({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p, input string nm);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.in1   = a;
        u_if.in2   = b;
        sb.push_back(p);
        wait_done(exp_lat(b), 1'b1, nm);
        @(negedge clk);
        check({nm, " done pulse width"}, {31'b0, u_if.done}, 32'd0);
        check({nm, " busy after DONE"}, {31'b0, u_if.busy}, 32'd0);
        check({nm, " out holds"}, u_if.out, p);
    endtask

    initial begin
        int ndone;
        checks = 0;
        errors = 0;
        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[3] = '{16'h1234, 16'h0001, 32'h00001234};
        vecs[4] = '{16'hABCD, 16'h0000, 32'h00000000};
        vecs[5] = '{16'hFFFF, 16'h8000, 32'h7FFF8000};
        vecs[6] = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[7] = '{16'd250,  16'd4,    32'd1000};

        rst = 1'b1;
        u_if.start = 1'b0;
        u_if.in1 = '0;
        u_if.in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, u_if.busy}, 32'd0);
        check("reset done", {31'b0, u_if.done}, 32'd0);
        check("reset out", u_if.out, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // Asynchronous abort after five RUN edges, with a nonzero previous out.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.in1 = 16'd3;
        u_if.in2 = 16'd5;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'b0, u_if.busy}, 32'd0);
        check("abort done", {31'b0, u_if.done}, 32'd0);
        check("abort out", u_if.out, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd2, 16'd2, 32'd4, "post-reset");

        // Second start while busy must be ignored.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.in1 = 16'd7;
        u_if.in2 = 16'd9;
        sb.push_back(32'd63);
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.in1 = 16'd100;
        u_if.in2 = 16'd100;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (u_if.done) begin
                ndone++;
                if (sb.size() != 0) check("busy-ignore out", u_if.out, sb.pop_front());
            end
        end
        check("busy-ignore done count", ndone, 32'd1);
        check("busy-ignore out holds", u_if.out, 32'd63);
        check("busy-ignore idle", {31'b0, u_if.busy}, 32'd0);

        // start held high: back-to-back products.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.in1 = 16'h1234;
        u_if.in2 = 16'h0010;
        sb.push_back(32'h00012340);
        sb.push_back(32'h00012340);
        wait_done(exp_lat(16'h0010), 1'b0, "held first");
        wait_done(exp_lat(16'h0010) + 1, 1'b0, "held second");
        u_if.start = 1'b0;
        @(negedge clk);
        check("held done pulse width", {31'b0, u_if.done}, 32'd0);
        check("held busy after", {31'b0, u_if.busy}, 32'd0);
        check("scoreboard drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
